// File: rtl/pe_pkg.sv
// Shared PE-array definitions: geometry, Q7.9 result format and the drain FSM encoding.
package pe_pkg;

  localparam int PE_COL       = 16;
  localparam int PE_ROW       = 2;
  localparam int PE_DW        = 16;
  localparam int PE_INT_BITS  = 7;
  localparam int PE_FRAC_BITS = 9;

  typedef logic [PE_DW-1:0]     pe_val_t;
  typedef pe_val_t [PE_COL-1:0] pe_row_t;
  typedef pe_row_t [PE_ROW-1:0] pe_tile_t;

  // Read-side FSM of pe_result_drain
  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/pe_tile_fifo.sv
// Circular tile buffer for pe_result_drain: storage, wrapping pointers, occupancy count.
// A push into a full buffer is accepted only when a pop happens in the same cycle; otherwise it is dropped.
module pe_tile_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 512,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          push_o,
  output logic          drop_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (count_q == CW'(DEPTH));
  assign push_o = push_req_i && (!full || pop_i);
  assign drop_o = push_req_i && full && !pop_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_o) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_o, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count_q, and a reset-free array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_o) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/pe_result_drain.sv
// PE-array output stage: buffers finished tiles and streams them one row per beat over valid/ready.
// Define PE_DRAIN_RELU_EN to zero negative values on the read path (stored tiles stay unmodified).
module pe_result_drain
  import pe_pkg::*;
#(
  parameter  int COL   = PE_COL,
  parameter  int ROW   = PE_ROW,
  parameter  int DW    = PE_DW,
  parameter  int DEPTH = 2,
  localparam int RCW   = $clog2(ROW),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROW-1:0][COL-1:0][DW-1:0] tile_in,
  input  logic                           tile_valid,
  output logic [COL*DW-1:0]              out_data,
  output logic [RCW-1:0]                 out_row,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CW-1:0]                  buf_count,
  output logic                           overflow,
  output logic [7:0]                     drop_cnt,
  input  logic                           clr_overflow
);

  logic [ROW-1:0][COL*DW-1:0] rd_tile;
  logic [COL*DW-1:0]          row_sel;
  logic                       push, drop, beat, last_row, pop;

  logic [0:0]     state_q, state_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  pe_tile_fifo #(
    .DEPTH (DEPTH),
    .W     (ROW * COL * DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (tile_valid),
    .pop_i      (pop),
    .wr_data_i  (tile_in),
    .rd_data_o  (rd_tile),
    .count_o    (buf_count),
    .push_o     (push),
    .drop_o     (drop)
  );

  assign out_valid = (state_q == ST_STREAM);
  assign last_row  = (row_cnt_q == RCW'(ROW - 1));
  assign beat      = out_valid && out_ready;
  assign pop       = beat && last_row;

  // A push into an empty buffer is visible one cycle later; a pop of the last held tile returns to EMPTY.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    if (beat) row_cnt_d = last_row ? '0 : row_cnt_q + RCW'(1);
    case (state_q)
      ST_EMPTY:  if (push) state_d = ST_STREAM;
      ST_STREAM: if (pop && (buf_count == CW'(1)) && !push) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)              drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign row_sel  = rd_tile[row_cnt_q];
  assign out_row  = row_cnt_q;
  assign out_last = out_valid && last_row;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Lanes are gated by the registered state so out_data reads zero while idle.
  for (genvar c = 0; c < COL; c++) begin : g_lane
    logic [DW-1:0] val;
    assign val = row_sel[c*DW +: DW];
`ifdef PE_DRAIN_RELU_EN
    assign out_data[c*DW +: DW] = (out_valid && !val[DW-1]) ? val : '0;
`else
    assign out_data[c*DW +: DW] = out_valid ? val : '0;
`endif
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed self-checking bench for pe_result_drain (DEPTH=2); honours PE_DRAIN_RELU_EN in its model.
module tb_pe_result_drain;
  import pe_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  pe_tile_t        tile_in;
  logic            tile_valid;
  logic [255:0]    out_data;
  logic [0:0]      out_row;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      buf_count;
  logic            overflow;
  logic [7:0]      drop_cnt;
  logic            clr_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_result_drain #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .tile_in      (tile_in),
    .tile_valid   (tile_valid),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .buf_count    (buf_count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .clr_overflow (clr_overflow)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // value[r][c] = base + r*16 + c
  function automatic pe_tile_t make_tile(input int base);
    pe_tile_t t;
    for (int r = 0; r < PE_ROW; r++)
      for (int c = 0; c < PE_COL; c++)
        t[r][c] = 16'(base + r * 16 + c);
    return t;
  endfunction

  function automatic logic [255:0] exp_row(input pe_tile_t t, input int r);
    logic [255:0] d;
    for (int c = 0; c < PE_COL; c++) begin
      d[c*16 +: 16] = t[r][c];
`ifdef PE_DRAIN_RELU_EN
      if (t[r][c][15]) d[c*16 +: 16] = 16'h0000;
`endif
    end
    return d;
  endfunction

  task automatic expect_beat(input string tag, input pe_tile_t t, input int r);
    check({tag, "_valid"}, 256'(out_valid), 256'(1));
    check({tag, "_row"},   256'(out_row),   256'(r));
    check({tag, "_last"},  256'(out_last),  256'(r == PE_ROW - 1));
    check({tag, "_data"},  out_data,        exp_row(t, r));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_bufcnt"}, 256'(buf_count), 256'(0));
  endtask

  task automatic push_tile(input pe_tile_t t);
    tile_in    = t;
    tile_valid = 1'b1;
  endtask

  pe_tile_t t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, tr;
  logic [255:0] held;

  initial begin
    t0 = make_tile(16'h0000); t1 = make_tile(16'h0100); t2 = make_tile(16'h0200);
    t3 = make_tile(16'h0300); t4 = make_tile(16'h0400); t5 = make_tile(16'h0500);
    t6 = make_tile(16'h0600); t7 = make_tile(16'h0700); t8 = make_tile(16'h0800);
    t9 = make_tile(16'h0900);
    for (int c = 0; c < PE_COL; c++) begin
      tr[0][c] = (c % 2 == 0) ? 16'hFE00 : 16'h0200;
      tr[1][c] = 16'h0200;
    end

    rst = 1'b1; tile_in = '0; tile_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid",    256'(out_valid), 256'(0));
    check("rst_last",     256'(out_last),  256'(0));
    check("rst_row",      256'(out_row),   256'(0));
    check("rst_data",     out_data,        256'(0));
    check("rst_bufcnt",   256'(buf_count), 256'(0));
    check("rst_overflow", 256'(overflow),  256'(0));
    check("rst_dropcnt",  256'(drop_cnt),  256'(0));
    rst = 1'b0;

    // Single tile, ready high: beats in the two cycles after the pulse
    @(negedge clk); push_tile(t0); out_ready = 1'b1;
    @(negedge clk); tile_valid = 1'b0;
    expect_beat("t1_b0", t0, 0);
    check("t1_bufcnt", 256'(buf_count), 256'(1));
    @(negedge clk);
    expect_beat("t1_b1", t0, 1);
    check("t1_lane0", 256'(out_data[15:0]), 256'(16'h0010));
    @(negedge clk);
    expect_idle("t1_end");

    // Backpressure: five stalled cycles, outputs frozen
    out_ready = 1'b0; push_tile(t1);
    @(negedge clk); tile_valid = 1'b0;
    held = out_data;
    check("bp_first", held, exp_row(t1, 0));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 256'(out_valid), 256'(1));
      check("bp_row",   256'(out_row),   256'(0));
      check("bp_data",  out_data,        exp_row(t1, 0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_beat("bp_b0", t1, 0);
    @(negedge clk); expect_beat("bp_b1", t1, 1);
    @(negedge clk); expect_idle("bp_end");

    // Overflow: three pushes with ready low
    out_ready = 1'b0;
    push_tile(t2); @(negedge clk);
    push_tile(t3); @(negedge clk);
    push_tile(t4); @(negedge clk);
    tile_valid = 1'b0;
    check("ov_bufcnt",  256'(buf_count), 256'(2));
    check("ov_flag",    256'(overflow),  256'(1));
    check("ov_dropcnt", 256'(drop_cnt),  256'(1));
    clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    check("ov_clr_flag",    256'(overflow), 256'(0));
    check("ov_clr_dropcnt", 256'(drop_cnt), 256'(0));
    out_ready = 1'b1;
    expect_beat("ov_t2b0", t2, 0);
    @(negedge clk); expect_beat("ov_t2b1", t2, 1);
    @(negedge clk); expect_beat("ov_t3b0", t3, 0);
    @(negedge clk); expect_beat("ov_t3b1", t3, 1);
    @(negedge clk); expect_idle("ov_end");

    // Full buffer, push coincides with the last-beat pop
    out_ready = 1'b0;
    push_tile(t5); @(negedge clk);
    push_tile(t6); @(negedge clk);
    tile_valid = 1'b0; out_ready = 1'b1;
    expect_beat("fp_t5b0", t5, 0);
    check("fp_full", 256'(buf_count), 256'(2));
    @(negedge clk);
    expect_beat("fp_t5b1", t5, 1);
    push_tile(t7);
    @(negedge clk); tile_valid = 1'b0;
    check("fp_bufcnt",  256'(buf_count), 256'(2));
    check("fp_nodrop",  256'(drop_cnt),  256'(0));
    check("fp_noflag",  256'(overflow),  256'(0));
    expect_beat("fp_t6b0", t6, 0);
    @(negedge clk); expect_beat("fp_t6b1", t6, 1);
    @(negedge clk); expect_beat("fp_t7b0", t7, 0);
    @(negedge clk); expect_beat("fp_t7b1", t7, 1);
    @(negedge clk); expect_idle("fp_end");

    // Reset after beat 0 of a tile
    push_tile(t8);
    @(negedge clk); tile_valid = 1'b0;
    expect_beat("mr_b0", t8, 0);
    @(negedge clk);
    expect_beat("mr_b1", t8, 1);
    rst = 1'b1;
    #1;
    check("mr_valid",  256'(out_valid), 256'(0));
    check("mr_bufcnt", 256'(buf_count), 256'(0));
    check("mr_row",    256'(out_row),   256'(0));
    #1 rst = 1'b0;
    @(negedge clk); push_tile(t9);
    @(negedge clk); tile_valid = 1'b0;
    expect_beat("mr_t9b0", t9, 0);
    @(negedge clk); expect_beat("mr_t9b1", t9, 1);
    @(negedge clk); expect_idle("mr_end");

    // ReLU read path: -1.0 and +1.0 lanes
    push_tile(tr);
    @(negedge clk); tile_valid = 1'b0;
    expect_beat("relu_b0", tr, 0);
`ifdef PE_DRAIN_RELU_EN
    check("relu_neg", 256'(out_data[15:0]), 256'(16'h0000));
`else
    check("relu_neg", 256'(out_data[15:0]), 256'(16'hFE00));
`endif
    check("relu_pos", 256'(out_data[31:16]), 256'(16'h0200));
    @(negedge clk); expect_beat("relu_b1", tr, 1);
    @(negedge clk); expect_idle("relu_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
